sc_window_counter_mc: RTL and testbench

- Multi-channel stochastic-to-binary converter. Counts '1' bits on NCH parallel stochastic bitstreams over a programmable sample window.
- Presents per-channel counts with a valid/ready handshake.
- Supports one-shot and continuous (back-to-back window) modes.
- Sits at the output of the stochastic compute fabric, feeding binary consumers such as the display/UART path.

---
 rtl/sc_window_counter_mc.sv | 164 ++++++++++++++++
 tb/tb_sc_window_counter_mc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_window_counter_mc.sv
// sc_window_counter_mc
// Multi-channel stochastic-to-binary converter. It counts the '1' bits on NCH
// parallel stochastic bitstreams over a programmable sample window and presents
// the per-channel counts through a valid/ready handshake. It supports one-shot
// and continuous (back-to-back window) operation.
//
// Optional build macro: SC_BIPOLAR_EN
//   If defined, the block adds a signed bipolar_out port. Channel i of this port
//   is 2*count[i] - window_length. It is registered together with counts.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; a zero-length window completes immediately
// S_COUNT | accumulating samples; window end transfers acc to counts
// S_HOLD  | one-shot result presented; leaves on handshake
module sc_window_counter_mc #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [CW-1:0]     window,
  input  logic [NCH-1:0]    sc_bits,
  output logic [NCH*CW-1:0] counts,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun
`ifdef SC_BIPOLAR_EN
  ,
  output logic signed [NCH*(CW+1)-1:0] bipolar_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t            state;
  logic              cont_q;
  logic [CW-1:0]     smp_left;   // samples remaining after the current one
  logic [NCH*CW-1:0] acc;
  logic [NCH*CW-1:0] acc_nxt;
  logic              accept;
  logic              start_go;
  logic              win_end;

  assign accept   = out_valid & out_ready;
  assign start_go = (state == S_IDLE) & start;
  assign win_end  = (state == S_COUNT) & (smp_left == '0);
  assign busy     = (state == S_COUNT);

  // The current cycle's bits are added to every channel, so the window's final
  // sample is included when the result is transferred.
  always_comb begin
    acc_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      acc_nxt[i*CW +: CW] = acc[i*CW +: CW] + {{(CW-1){1'b0}}, sc_bits[i]};
    end
  end

  // Window sequencing, accumulation, result transfer and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cont_q    <= 1'b0;
      smp_left  <= '0;
      acc       <= '0;
      counts    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start_go) begin
            cont_q   <= continuous;
            acc      <= '0;
            smp_left <= window - ONE;
            overrun  <= 1'b0;
            if (window == '0) begin
              // An empty window has an all-zero result. It never free-runs,
              // even when continuous is requested.
              counts    <= '0;
              out_valid <= 1'b1;
              state     <= continuous ? S_IDLE : S_HOLD;
            end else begin
              state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          if (win_end) begin
            counts    <= acc_nxt;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
              overrun <= 1'b1;
            end
            if (cont_q) begin
              // The restart has no gap: the next cycle is sample 0 of the
              // new window.
              cont_q   <= continuous;
              acc      <= '0;
              smp_left <= window - ONE;
              if (window == '0) begin
                state <= S_HOLD;
              end
            end else begin
              state <= S_HOLD;
            end
          end else begin
            acc      <= acc_nxt;
            smp_left <= smp_left - ONE;
          end
        end
        S_HOLD: begin
          if (accept || !out_valid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SC_BIPOLAR_EN
  logic [CW-1:0]          win_q;
  logic [NCH*(CW+1)-1:0]  bip_nxt;

  // 2*count - window wraps correctly in CW+1 bits because |result| <= window.
  always_comb begin
    bip_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      bip_nxt[i*(CW+1) +: (CW+1)] = {acc_nxt[i*CW +: CW], 1'b0} - {1'b0, win_q};
    end
  end

  // Window-length tracking and bipolar result, loaded alongside counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q       <= '0;
      bipolar_out <= '0;
    end else begin
      if (start_go || (win_end && cont_q)) begin
        win_q <= window;
      end
      if (start_go && (window == '0)) begin
        bipolar_out <= '0;
      end else if (win_end) begin
        bipolar_out <= bip_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sc_window_counter_mc.sv
// Directed bench for sc_window_counter_mc (NCH=4, CW=16).
// This bench also covers bipolar_out when SC_BIPOLAR_EN is defined.
module tb_sc_window_counter_mc;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              continuous;
  logic [CW-1:0]     window;
  logic [NCH-1:0]    sc_bits;
  logic [NCH*CW-1:0] counts;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              overrun;
`ifdef SC_BIPOLAR_EN
  logic [NCH*(CW+1)-1:0] bipolar_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sc_window_counter_mc #(.NCH(NCH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .window     (window),
    .sc_bits    (sc_bits),
    .counts     (counts),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef SC_BIPOLAR_EN
    ,
    .bipolar_out(bipolar_out)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0; window = '0;
    sc_bits = '0; out_ready = 1'b0;
    tick; tick;
    check_val("rst_counts", counts, 64'h0);
    check_val("rst_valid", out_valid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    tick;

    // One-shot, window 8, result held with out_ready low
    window = 16'd8; start = 1'b1;
    tick;
    start = 1'b0;
    check_val("os_busy", busy, 1'b1);
    for (int s = 0; s < 8; s++) begin
      sc_bits = {(s == 7), 1'b0, (s % 2 == 0), 1'b1};
      if (s == 7) check_val("os_valid_early", out_valid, 1'b0);
      tick;
    end
    sc_bits = '0;
    check_val("os_valid", out_valid, 1'b1);
    check_val("os_counts", counts, 64'h0001_0000_0004_0008);
    check_val("os_busy_done", busy, 1'b0);
    repeat (3) tick;
    check_val("os_valid_held", out_valid, 1'b1);
    check_val("os_counts_held", counts, 64'h0001_0000_0004_0008);
`ifdef SC_BIPOLAR_EN
    check_val("os_bip_ch0", bipolar_out[0*17 +: 17], 17'h00008);
    check_val("os_bip_ch1", bipolar_out[1*17 +: 17], 17'h00000);
    check_val("os_bip_ch2", bipolar_out[2*17 +: 17], 17'h1FFF8);
    check_val("os_bip_ch3", bipolar_out[3*17 +: 17], 17'h1FFFA);
`endif
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_val("os_valid_drop", out_valid, 1'b0);
    check_val("os_idle_busy", busy, 1'b0);

    // Reset in the middle of a window of 10
    window = 16'd10; start = 1'b1; sc_bits = 4'hF;
    tick;
    start = 1'b0;
    repeat (5) tick;
    check_val("rmw_busy", busy, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    sc_bits = '0;
    check_val("rmw_counts", counts, 64'h0);
    check_val("rmw_valid", out_valid, 1'b0);
    check_val("rmw_busy_clr", busy, 1'b0);
    tick;
    check_val("rmw_idle", busy, 1'b0);

    // Continuous, window 4, consumer always ready
    sc_bits = 4'b0001; window = 16'd4; continuous = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 9) continuous = 1'b0;
      tick;
      check_val($sformatf("cont_valid_c%0d", c), out_valid, (c % 4 == 0));
      if (c % 4 == 0) check_val($sformatf("cont_counts_c%0d", c), counts, 64'h0000_0000_0000_0004);
    end
    check_val("cont_busy_end", busy, 1'b0);
    check_val("cont_overrun", overrun, 1'b0);
    tick;
    check_val("cont_final_accept", out_valid, 1'b0);
    out_ready = 1'b0;
    sc_bits = '0;

    // Zero-length window
    window = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    check_val("zw_valid", out_valid, 1'b1);
    check_val("zw_counts", counts, 64'h0);
    check_val("zw_busy", busy, 1'b0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_val("zw_valid_drop", out_valid, 1'b0);
    check_val("zw_busy_after", busy, 1'b0);

    // Overrun in continuous mode, window 3, consumer stalled
    window = 16'd3; continuous = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      sc_bits = (c <= 3) ? 4'b0011 : ((c <= 6) ? 4'b0001 : 4'b0100);
      if (c == 4) continuous = 1'b0;
      tick;
      if (c == 3) begin
        check_val("ov_valid1", out_valid, 1'b1);
        check_val("ov_counts1", counts, 64'h0000_0000_0003_0003);
        check_val("ov_flag1", overrun, 1'b0);
      end
      if (c == 6) begin
        check_val("ov_valid2", out_valid, 1'b1);
        check_val("ov_counts2", counts, 64'h0000_0000_0000_0003);
        check_val("ov_flag2", overrun, 1'b1);
      end
      if (c == 9) begin
        check_val("ov_counts3", counts, 64'h0000_0003_0000_0000);
        check_val("ov_busy3", busy, 1'b0);
      end
    end
    sc_bits = '0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check_val("ov_valid_drop", out_valid, 1'b0);
    tick;
    check_val("ov_sticky", overrun, 1'b1);
    window = 16'd1; sc_bits = 4'b1000; start = 1'b1;
    tick;
    start = 1'b0;
    check_val("ov_cleared", overrun, 1'b0);
    check_val("w1_busy", busy, 1'b1);
    tick;
    sc_bits = '0;
    check_val("w1_valid", out_valid, 1'b1);
    check_val("w1_counts", counts, 64'h0001_0000_0000_0000);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

`ifdef SC_BIPOLAR_EN
    // Bipolar: window 8, channel 0 has two ones, so the expected result is -4
    window = 16'd8; start = 1'b1;
    tick;
    start = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sc_bits = (s < 2) ? 4'b0001 : 4'b0000;
      tick;
    end
    sc_bits = '0;
    check_val("bip_counts", counts, 64'h0000_0000_0000_0002);
    check_val("bip_ch0", bipolar_out[0*17 +: 17], 17'h1FFFC);
    check_val("bip_ch1", bipolar_out[1*17 +: 17], 17'h1FFF8);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
